temp_reg_stack: RTL

Parametrised successor to the 16-bit microcode temporary register. Keeps a visible top value (val) plus a LIFO of DEPTH saved levels, so microcode can save and restore temporaries across nested sequences. Writes to the top support per-byte enables. Sits in the CPU core next to the microcode sequencer; val feeds the ALU/bus mux exactly as the single temp register did.

---
 rtl/temp_reg_stack.sv | 77 +++++++
 1 files changed

// File: rtl/temp_reg_stack.sv
// temp_reg_stack: microcode temp register with byte-enabled writes and a DEPTH-level save/restore LIFO.
// Define TEMP_REG_STACK_ERR_EN to build the sticky overflow/underflow flags.
module temp_reg_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int NB = WIDTH / 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_val,
    input  logic             wr_en,
    input  logic [NB-1:0]    wr_be,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] val,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    // Storage is sized to the index range so level can address it without truncation.
    logic [WIDTH-1:0] mem [2**LW];
    logic [WIDTH-1:0] merged;
    logic [LW-1:0]    top_idx;
    logic             do_push, do_pop, wr_top;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        assign merged[8*k +: 8] = wr_be[k] ? wr_val[8*k +: 8] : val[8*k +: 8];
    end

    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign top_idx = level - 1'b1;
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    // A lone pop (successful or not) swallows any write in the same cycle.
    assign wr_top  = wr_en & ~(pop & ~push);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val   <= RESET_VAL;
            level <= '0;
        end else begin
            val   <= do_pop ? mem[top_idx] : wr_top ? merged : val;
            level <= do_push ? level + 1'b1 : do_pop ? top_idx : level;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[level] <= val;
    end

`ifdef TEMP_REG_STACK_ERR_EN
    logic ovf_ev, unf_ev;
    assign ovf_ev = push & ~pop & full;
    assign unf_ev = pop & ~push & empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_ev | (overflow & ~err_clr);
            underflow <= unf_ev | (underflow & ~err_clr);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif
endmodule
